// File: rtl/floor_request_scheduler.sv
// floor_request_scheduler
//   Upstream stage of the elevator controller. Synchronises the raw call buttons,
//   keeps a bitmap of outstanding floor requests and picks the next target floor
//   with a SCAN policy: keep serving in the current direction, reverse only when
//   nothing is left ahead of the car.
//
//   Optional feature macro: FLOOR_REQ_DEBOUNCE_EN
//     defined   -> per-button debounce counter (DEBOUNCE_CYCLES stable cycles)
//                  between the synchroniser and the edge detector.
//     undefined -> edge detector works directly on the synchroniser output.
module floor_request_scheduler #(
   parameter int NUM_FLOORS      = 8,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [NUM_FLOORS-1:0] call_btn_i,
   input  logic [3:0]            current_floor_i,
   input  logic                  car_idle_i,
   output logic [3:0]            requested_floor_o,
   output logic                  req_active_o,
   output logic [NUM_FLOORS-1:0] pending_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_UP   = 2'd1;
   localparam logic [1:0] ST_DOWN = 2'd2;

   localparam logic [3:0] FLOOR_LIMIT = 4'(NUM_FLOORS);

   logic [NUM_FLOORS-1:0] sync1_q;
   logic [NUM_FLOORS-1:0] sync2_q;
   logic [1:0]            settle_q;
   logic [NUM_FLOORS-1:0] armed_q;
   logic [NUM_FLOORS-1:0] armed_d;
   logic [NUM_FLOORS-1:0] level;
   logic [NUM_FLOORS-1:0] lvl_prev_q;
   logic [NUM_FLOORS-1:0] rise;
   logic [NUM_FLOORS-1:0] clr;
   logic [NUM_FLOORS-1:0] pending_q;
   logic [NUM_FLOORS-1:0] pending_d;
   logic [1:0]            state_q;
   logic [1:0]            state_d;
   logic [3:0]            requested_floor_q;
   logic [3:0]            requested_floor_d;
   logic                  in_range;
   logic                  up_found;
   logic                  dn_found;
   logic [3:0]            up_tgt;
   logic [3:0]            dn_tgt;

   assign in_range = (current_floor_i < FLOOR_LIMIT);

   // Two-flop synchroniser; settle counter marks when sync2_q reflects real button levels again
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         settle_q <= '0;
      end else begin
         sync1_q <= call_btn_i;
         sync2_q <= sync1_q;
         if (settle_q != 2'd2) begin
            settle_q <= settle_q + 2'd1;
         end
      end
   end

   // A button becomes eligible for edge detection only once it has been seen released
   // after reset, so a press held through reset is ignored until re-pressed.
   always_comb begin
      armed_d = armed_q;
      if (settle_q == 2'd2) begin
         armed_d = armed_q | ~sync2_q;
      end
   end

   // Arm register update
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         armed_q <= '0;
      end else begin
         armed_q <= armed_d;
      end
   end

`ifdef FLOOR_REQ_DEBOUNCE_EN
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) + 1 : 1;

   logic [NUM_FLOORS-1:0] deb_q;
   logic [CNT_W-1:0]      cnt_q [NUM_FLOORS];

   // Debounce: the level follows the synchroniser only after DEBOUNCE_CYCLES consecutive differing cycles
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         deb_q <= '0;
         for (int i = 0; i < NUM_FLOORS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_FLOORS; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
               if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                  deb_q[i] <= sync2_q[i];
                  cnt_q[i] <= '0;
               end else begin
                  cnt_q[i] <= cnt_q[i] + 1'b1;
               end
            end else begin
               cnt_q[i] <= '0;
            end
         end
      end
   end

   assign level = deb_q;
`else
   assign level = sync2_q;
`endif

   // Previous level for rising-edge detection
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         lvl_prev_q <= '0;
      end else begin
         lvl_prev_q <= level;
      end
   end

   assign rise = level & ~lvl_prev_q & armed_q;

   // Arrival clear: car stopped at its target floor retires that request; clear beats a same-cycle set
   always_comb begin
      clr = '0;
      if (car_idle_i && in_range && (current_floor_i == requested_floor_q)) begin
         for (int i = 0; i < NUM_FLOORS; i++) begin
            if (current_floor_i == 4'(i)) begin
               clr[i] = 1'b1;
            end
         end
      end
   end

   assign pending_d = (pending_q | rise) & ~clr;

   // Nearest request strictly above (lowest such bit) and strictly below (highest such bit)
   always_comb begin
      up_found = 1'b0;
      up_tgt   = '0;
      dn_found = 1'b0;
      dn_tgt   = '0;
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
         if (pending_d[i] && (4'(i) > current_floor_i)) begin
            up_found = 1'b1;
            up_tgt   = 4'(i);
         end
      end
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (pending_d[i] && (4'(i) < current_floor_i)) begin
            dn_found = 1'b1;
            dn_tgt   = 4'(i);
         end
      end
   end

   // SCAN next-state and target selection, evaluated on the next pending bitmap
   always_comb begin
      state_d           = state_q;
      requested_floor_d = requested_floor_q;
      if (!in_range) begin
         // Lost position: send the car home to floor 0, keep requests for later
         state_d           = ST_IDLE;
         requested_floor_d = '0;
      end else if (pending_d == '0) begin
         state_d           = ST_IDLE;
         requested_floor_d = current_floor_i;
      end else begin
         case (state_q)
            ST_UP: begin
               if (up_found) begin
                  state_d           = ST_UP;
                  requested_floor_d = up_tgt;
               end else if (dn_found) begin
                  state_d           = ST_DOWN;
                  requested_floor_d = dn_tgt;
               end else begin
                  state_d           = ST_UP;
                  requested_floor_d = current_floor_i;
               end
            end
            ST_DOWN: begin
               if (dn_found) begin
                  state_d           = ST_DOWN;
                  requested_floor_d = dn_tgt;
               end else if (up_found) begin
                  state_d           = ST_UP;
                  requested_floor_d = up_tgt;
               end else begin
                  state_d           = ST_DOWN;
                  requested_floor_d = current_floor_i;
               end
            end
            default: begin
               // From IDLE, ties between above and below favour going up
               if (up_found) begin
                  state_d           = ST_UP;
                  requested_floor_d = up_tgt;
               end else if (dn_found) begin
                  state_d           = ST_DOWN;
                  requested_floor_d = dn_tgt;
               end else begin
                  state_d           = ST_DOWN;
                  requested_floor_d = current_floor_i;
               end
            end
         endcase
      end
   end

   // Pending bitmap, scheduler state and registered target
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pending_q         <= '0;
         state_q           <= ST_IDLE;
         requested_floor_q <= '0;
      end else begin
         pending_q         <= pending_d;
         state_q           <= state_d;
         requested_floor_q <= requested_floor_d;
      end
   end

   assign requested_floor_o = requested_floor_q;
   assign req_active_o      = (state_q != ST_IDLE);
   assign pending_o         = pending_q;

endmodule
